// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and width helpers for the LED pulse stretcher.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event-in / LED-out bundle between the event logic and the pulse stretcher.
interface led_pulse_stretcher_if #(
  parameter int unsigned PEND_MAX = 15
);
  import led_pulse_stretcher_pkg::*;

  localparam int unsigned PW = width_for(PEND_MAX + 1);

  logic          event_in;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  modport master (
    output event_in,
    input  led,
    input  busy,
    input  pending,
    input  dropped
  );

  modport slave (
    input  event_in,
    output led,
    output busy,
    output pending,
    output dropped
  );

endinterface

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle events into fixed-length LED blinks with a queued,
// saturating backlog so every event gets its own blink.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000,
  parameter int unsigned PEND_MAX   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  led_pulse_stretcher_if.slave bus
);

  localparam int unsigned TW = width_for(max_u(ON_CYCLES, OFF_CYCLES));
  localparam int unsigned PW = width_for(PEND_MAX + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_LIM = PW'(PEND_MAX);

  stretch_state_t r_state;
  stretch_state_t w_state_next;

  logic [PW-1:0] r_pending;
  logic [PW-1:0] w_pending_next;
  logic          r_led;
  logic          r_busy;
  logic          r_dropped;
  logic          w_dropped_next;
  logic          w_enqueue;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_expired;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_dropped_next = 1'b0;
    w_enqueue      = 1'b0;
    w_load         = 1'b0;
    w_load_val     = ON_LOAD;

    case (r_state)
      IDLE: begin
        if (bus.event_in) begin
          w_state_next = ON;
          w_load       = 1'b1;
          w_load_val   = ON_LOAD;
        end
      end

      ON: begin
        w_enqueue = bus.event_in;
        if (w_expired) begin
          w_state_next = GAP;
          w_load       = 1'b1;
          w_load_val   = GAP_LOAD;
        end
      end

      GAP: begin
        if (w_expired) begin
          if (r_pending != '0) begin
            // Oldest queued event starts now; a same-cycle event takes its slot.
            w_state_next = ON;
            w_load       = 1'b1;
            w_load_val   = ON_LOAD;
            if (!bus.event_in) begin
              w_pending_next = r_pending - PW'(1);
            end
          end else if (bus.event_in) begin
            w_state_next = ON;
            w_load       = 1'b1;
            w_load_val   = ON_LOAD;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_enqueue = bus.event_in;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_enqueue) begin
      if (r_pending < PEND_LIM) begin
        w_pending_next = r_pending + PW'(1);
      end else begin
        w_dropped_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_led     <= (w_state_next == ON);
      r_busy    <= (w_state_next != IDLE);
      r_dropped <= w_dropped_next;
    end
  end

  assign bus.led     = r_led;
  assign bus.busy    = r_busy;
  assign bus.pending = r_pending;
  assign bus.dropped = r_dropped;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=4, OFF=3, PEND_MAX=2.
module tb_led_pulse_stretcher;

  localparam int unsigned ON_C  = 4;
  localparam int unsigned OFF_C = 3;
  localparam int unsigned PM    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   c      = 0;

  led_pulse_stretcher_if #(.PEND_MAX(PM)) bus_if ();

  led_pulse_stretcher #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .PEND_MAX   (PM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic el, input logic eb,
                         input int ep, input logic ed);
    chk({tag, ".led"},     32'(bus_if.led),     32'(el));
    chk({tag, ".busy"},    32'(bus_if.busy),    32'(eb));
    chk({tag, ".pending"}, 32'(bus_if.pending), 32'(ep));
    chk({tag, ".dropped"}, 32'(bus_if.dropped), 32'(ed));
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus_if.event_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    c = 0;
  endtask

  task automatic start_cycle(input logic ev);
    bus_if.event_in = ev;
    @(negedge clk);
  endtask

  task automatic end_cycle;
    @(posedge clk);
    #1;
    c++;
  endtask

  // Hand-derived windows for three queued blinks starting at cycle 11.
  function automatic logic led3(input int n);
    return (n >= 11 && n <= 14) || (n >= 18 && n <= 21) || (n >= 25 && n <= 28);
  endfunction

  function automatic logic busy3(input int n);
    return (n >= 11 && n <= 31);
  endfunction

  initial begin
    // Reset held three cycles, then idle with no events.
    reset = 1'b0;
    bus_if.event_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk_all("in_reset", 1'b0, 1'b0, 0, 1'b0);
    end
    reset = 1'b1;
    c = 0;
    repeat (8) begin
      start_cycle(1'b0);
      chk_all("idle", 1'b0, 1'b0, 0, 1'b0);
      end_cycle();
    end

    // Single event at cycle 10.
    do_reset();
    repeat (22) begin
      start_cycle(c == 10);
      chk_all("single", (c >= 11 && c <= 14), (c >= 11 && c <= 17), 0, 1'b0);
      end_cycle();
    end

    // Events at 10, 12, 13: two queued, three blinks.
    do_reset();
    repeat (36) begin
      start_cycle(c == 10 || c == 12 || c == 13);
      chk_all("queue", led3(c), busy3(c),
              (c == 13) ? 1 : (c >= 14 && c <= 17) ? 2 : (c >= 18 && c <= 24) ? 1 : 0,
              1'b0);
      end_cycle();
    end

    // Events at 10..13: saturation at 2, one dropped.
    do_reset();
    repeat (36) begin
      start_cycle(c >= 10 && c <= 13);
      chk_all("sat", led3(c), busy3(c),
              (c == 12) ? 1 : (c >= 13 && c <= 17) ? 2 : (c >= 18 && c <= 24) ? 1 : 0,
              (c == 14));
      end_cycle();
    end

    // Event coinciding with gap expiry while one is pending.
    do_reset();
    repeat (36) begin
      start_cycle(c == 10 || c == 12 || c == 17);
      chk_all("coincide", led3(c), busy3(c), (c >= 13 && c <= 24) ? 1 : 0, 1'b0);
      end_cycle();
    end

    // Reset asserted mid-blink with one pending.
    do_reset();
    repeat (12) begin
      start_cycle(c == 10 || c == 11);
      chk_all("mid_pre", (c >= 11), (c >= 11), 0, 1'b0);
      end_cycle();
    end
    start_cycle(1'b0);
    chk_all("mid_c12", 1'b1, 1'b1, 1, 1'b0);
    reset = 1'b0;
    #1 chk_all("mid_async", 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    c = 0;
    repeat (10) begin
      start_cycle(1'b0);
      chk_all("post_rst", 1'b0, 1'b0, 0, 1'b0);
      end_cycle();
    end
    start_cycle(1'b1);
    chk_all("new_ev", 1'b0, 1'b0, 0, 1'b0);
    end_cycle();
    start_cycle(1'b0);
    chk_all("new_blink", 1'b1, 1'b1, 0, 1'b0);
    end_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side companion to the button debouncer. It converts single-cycle event pulses, such as `button_down`, into human-visible LED blinks of fixed on-time, separated by a fixed off-gap. Events that arrive while a blink is in progress are queued in a saturating pending counter, so every press produces its own distinct blink. It sits between the debounced-button / event logic and a board LED pin.

## Interface
- `ON_CYCLES`, default 25_000_000: LED on-time per blink, in clk cycles; must be ≥ 1.
- `OFF_CYCLES`, default 12_500_000: mandatory LED-off gap after each blink, in clk cycles; must be ≥ 1.
- `PEND_MAX`, default 15: saturation limit of the pending-event counter; must be ≥ 1.
- `clk`  input  1  system clock; all logic on posedge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted); one clock only.
- `event_in`  input  1  single-cycle event pulse; synchronous to clk.
- `led`  output  1  LED drive, active-high.
- `busy`  output  1  high whenever state ≠ IDLE.
- `pending`  output  $clog2(PEND_MAX+1)  queued events not yet started.
- `dropped`  output  1  one-cycle pulse when an event is lost to saturation.

## Operation
- FSM states:
  - IDLE: led = 0, timer idle.
  - ON: led = 1, timer counts ON_CYCLES.
  - GAP: led = 0, timer counts OFF_CYCLES.
- IDLE → ON on `event_in`. This event is consumed directly and is not added to `pending`. IDLE always has `pending` = 0.
- ON → GAP when the on-timer expires.
- GAP → ON when the gap timer expires and (`pending` > 0 or `event_in`); otherwise GAP → IDLE.
  - Starting a blink from `pending` decrements it by 1.
  - Starting from a same-cycle `event_in` with `pending` = 0 consumes that event.
  - If `pending` > 0 and `event_in` is asserted in that same cycle, `pending` is unchanged: the event is enqueued and the oldest one is dequeued.
- In ON or GAP with no dequeue this cycle:
  - `event_in` increments `pending` if `pending` < PEND_MAX.
  - If `pending` = PEND_MAX, `pending` holds and `dropped` pulses for 1 cycle.
- `pending` never wraps and never underflows.
- `led`, `busy`, and `dropped` are registered outputs; `pending` is the counter register.
- Reset values: state = IDLE, `led` = 0, `busy` = 0, `pending` = 0, `dropped` = 0, timer = 0.
- Reset asserted mid-blink clears everything immediately, including queued events.
- On release, the block waits in IDLE for a new `event_in`.
- `event_in` held high for N cycles counts as N events. Upstream guarantees single-cycle pulses; the block does not edge-detect.

## Timing
- `event_in` high in cycle t while IDLE:
  - `led` and `busy` rise at t+1.
  - `led` stays high for exactly ON_CYCLES cycles (t+1 … t+ON_CYCLES).
  - `led` is low for exactly OFF_CYCLES cycles.
  - If nothing is pending, `busy` falls at t+1+ON_CYCLES+OFF_CYCLES.
- Back-to-back blinks from the queue have period ON_CYCLES+OFF_CYCLES exactly, with no IDLE cycle between them.
- `dropped` is asserted in the cycle after the lost `event_in`.
- Timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)).
- The timer loads the value −1 on state entry and expires when it reaches 0.

## Structure
- Package `led_pulse_stretcher_pkg`: `typedef enum logic [1:0] {IDLE, ON, GAP} stretch_state_t`, plus a width helper function for the timer and `pending` widths.
- Sub-module `cycle_timer`: loadable down-counter with parameter WIDTH, ports `clk`, `reset`, `load`, `load_val`, `expired`. It is reused for the ON and GAP phases.
- The FSM, the pending counter, and the output registers live in the top module.

## Test plan
Parameters: ON_CYCLES=4, OFF_CYCLES=3, PEND_MAX=2.
- Reset then idle: hold `reset` low for 3 cycles, release, no events → `led`/`busy`/`pending`/`dropped` = 0 throughout.
- Single event at cycle 10 → `led` = 1 for cycles 11–14, `led` = 0 for cycles 15–17, `busy` falls at cycle 18, `pending` stays 0.
- Events at cycles 10, 12, 13 → `pending` goes 1 then 2. Three blinks with `led` rising at cycles 11, 18, 25. `pending` = 1 after cycle 17 and 0 after cycle 24.
- Events at cycles 10, 11, 12, 13 → `pending` saturates at 2 and `dropped` pulses at cycle 14 only. Exactly 3 blinks occur.
- Event coinciding with the gap expiry (cycle 17) with `pending` = 1 → `pending` stays 1 and the next blink starts at cycle 18.
- Assert `reset` at cycle 12 mid-blink with `pending` = 1 → `led` = 0 and `pending` = 0 asynchronously. After release, no blink occurs until a new event arrives.
